// File: rtl/pipe_isa_pkg.sv
// ISA definitions for the 4-stage pipeline and its instruction issue unit.
// Shared by the processor and the issue front end.
package pipe_isa_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_LOAD = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3E;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_STALL = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  function automatic logic [5:0] op_of(input logic [31:0] w);
    return w[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] w);
    return w[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] w);
    return w[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] w);
    return w[RD_HI:RD_LO];
  endfunction

  function automatic logic uses_rs(input logic [31:0] w);
    return op_of(w) == OP_ADD || op_of(w) == OP_SUB
        || op_of(w) == OP_LOAD;
  endfunction

  function automatic logic uses_rt(input logic [31:0] w);
    return op_of(w) == OP_ADD || op_of(w) == OP_SUB;
  endfunction

  function automatic logic has_dst(input logic [31:0] w);
    return uses_rs(w);
  endfunction

  // LOAD writes rt; ALU ops write rd.
  function automatic logic [4:0] dst_of(input logic [31:0] w);
    return (op_of(w) == OP_LOAD) ? rt_of(w) : rd_of(w);
  endfunction

endpackage

// File: rtl/raw_hazard_check.sv
// Combinational RAW check of one instruction against
// the destinations of the most recently issued instructions.
module raw_hazard_check
  import pipe_isa_pkg::*;
#(
  parameter int WINDOW = 3
) (
  input  logic [31:0]             cur,
  input  logic [WINDOW-1:0]       hist_valid,
  input  logic [WINDOW-1:0][4:0]  hist_dst,
  output logic                    hit
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic       use_rs;
  logic       use_rt;
  logic       unused_bits;

  assign rs          = rs_of(cur);
  assign rt          = rt_of(cur);
  assign use_rs      = uses_rs(cur);
  assign use_rt      = uses_rt(cur);
  assign unused_bits = ^cur[15:0];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      if (hist_valid[i]
          && ((use_rs && hist_dst[i] == rs)
           || (use_rt && hist_dst[i] == rt)))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Program memory + PC feeding the pipeline, with NOP drain on halt.
// HAZARD_STALL_EN enables RAW bubble insertion and its history.
module instr_issue_unit
  import pipe_isa_pkg::*;
#(
  parameter  int DEPTH         = 16,
  parameter  int PIPE_DEPTH    = 4,
  parameter  int HAZARD_WINDOW = 3,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  input  logic          halt_req,
  output logic [31:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   bubble_count
);

  localparam int CW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  state_t        state;
  logic [CW-1:0] drn_cnt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   cur;
  logic          hit;

  assign cur  = mem[pc];
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (prog_we && state == ST_IDLE)
      mem[prog_addr] <= prog_data;
  end

`ifdef HAZARD_STALL_EN
  logic [HAZARD_WINDOW-1:0]      hv;
  logic [HAZARD_WINDOW-1:0][4:0] hd;
  logic                          issuing;

  assign issuing = (state == ST_RUN || state == ST_STALL)
                && !halt_req && op_of(cur) != OP_HALT;

  // Bubbles shift in an empty slot so a hazard ages out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv <= '0;
      hd <= '0;
    end else if (state == ST_IDLE) begin
      hv <= '0;
    end else if (issuing) begin
      for (int i = HAZARD_WINDOW - 1; i > 0; i--) begin
        hv[i] <= hv[i-1];
        hd[i] <= hd[i-1];
      end
      hv[0] <= !hit && has_dst(cur);
      hd[0] <= dst_of(cur);
    end
  end

  raw_hazard_check #(
    .WINDOW(HAZARD_WINDOW)
  ) u_raw (
    .cur       (cur),
    .hist_valid(hv),
    .hist_dst  (hd),
    .hit       (hit)
  );
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pc           <= '0;
      drn_cnt      <= '0;
      instruction  <= NOP_WORD;
      instr_valid  <= 1'b0;
      done         <= 1'b0;
      bubble_count <= '0;
    end else begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            pc           <= '0;
            bubble_count <= '0;
            state        <= ST_RUN;
          end
        end
        ST_RUN, ST_STALL: begin
          if (halt_req || op_of(cur) == OP_HALT) begin
            drn_cnt <= CW'(PIPE_DEPTH - 1);
            state   <= ST_DRAIN;
          end else if (hit) begin
            if (bubble_count != 16'hFFFF)
              bubble_count <= bubble_count + 16'd1;
            state <= ST_STALL;
          end else begin
            instruction <= cur;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drn_cnt == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            drn_cnt <= drn_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit; expectations follow
// whether HAZARD_STALL_EN is defined.
module tb_instr_issue_unit;
  import pipe_isa_pkg::*;

  localparam int AW = 4;

  localparam logic [31:0] I_ADD3  = 32'h0022_1800;
  localparam logic [31:0] I_SUB4  = 32'h04A6_2000;
  localparam logic [31:0] I_SUB43 = 32'h0461_2000;
  localparam logic [31:0] I_LD7   = 32'h0807_0000;
  localparam logic [31:0] I_ADD10 = 32'h0109_5000;
  localparam logic [31:0] I_ADD11 = 32'h00E8_5800;
  localparam logic [31:0] I_HALT  = 32'hF800_0000;
  localparam logic [31:0] I_NOP   = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [15:0]   bubble_count;

  int n_chk  = 0;
  int n_pass = 0;

  instr_issue_unit dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .halt_req    (halt_req),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [31:0] ei,
                      input logic ev, input logic eb,
                      input logic ed);
    tick();
    chk(tag, {done, busy, instr_valid, instruction},
        {ed, eb, ev, ei});
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a[AW-1:0];
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input string tag);
    start = 1'b1;
    step(tag, I_NOP, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
  endtask

  // First NOP is the one issued as the halt is seen.
  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++)
      step(tag, I_NOP, 1'b0, 1'b1, 1'b0);
    step({tag, "_done"}, I_NOP, 1'b0, 1'b0, 1'b1);
    step({tag, "_idle"}, I_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_t2(input string tag);
    go(tag);
    step(tag, I_ADD3, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_STALL_EN
    for (int i = 0; i < 3; i++)
      step({tag, "_bub"}, I_NOP, 1'b0, 1'b1, 1'b0);
`endif
    step(tag, I_SUB43, 1'b1, 1'b1, 1'b0);
    drain(tag);
`ifdef HAZARD_STALL_EN
    chk({tag, "_bcnt"}, bubble_count, 3);
`else
    chk({tag, "_bcnt"}, bubble_count, 0);
`endif
  endtask

  initial begin
    tick();
    chk("rst_out", {done, busy, instr_valid, instruction},
        {3'b000, I_NOP});
    chk("rst_pc", pc, 0);
    chk("rst_bcnt", bubble_count, 0);
    reset = 1'b0;
    tick();

    // 1: independent ADD, SUB then HALT
    wr(0, I_ADD3);
    wr(1, I_SUB4);
    wr(2, I_HALT);
    go("t1");
    step("t1_add", I_ADD3, 1'b1, 1'b1, 1'b0);
    step("t1_sub", I_SUB4, 1'b1, 1'b1, 1'b0);
    drain("t1_drn");
    chk("t1_bcnt", bubble_count, 0);

    // 2: SUB reads r3 right after ADD writes it
    wr(1, I_SUB43);
    run_t2("t2");

    // 3: LOAD r7, independent ADD, ADD reading r7
    wr(0, I_LD7);
    wr(1, I_ADD10);
    wr(2, I_ADD11);
    wr(3, I_HALT);
    go("t3");
    step("t3_ld", I_LD7, 1'b1, 1'b1, 1'b0);
    step("t3_ind", I_ADD10, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_STALL_EN
    step("t3_bub", I_NOP, 1'b0, 1'b1, 1'b0);
    step("t3_bub", I_NOP, 1'b0, 1'b1, 1'b0);
`endif
    step("t3_use", I_ADD11, 1'b1, 1'b1, 1'b0);
    drain("t3_drn");
`ifdef HAZARD_STALL_EN
    chk("t3_bcnt", bubble_count, 2);
`else
    chk("t3_bcnt", bubble_count, 0);
`endif

    // 4: halt_req two cycles after start
    wr(0, I_ADD3);
    wr(1, I_SUB4);
    wr(2, I_ADD10);
    go("t4");
    step("t4_i0", I_ADD3, 1'b1, 1'b1, 1'b0);
    step("t4_i1", I_SUB4, 1'b1, 1'b1, 1'b0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t4_h", {done, busy, instr_valid, instruction},
        {3'b010, I_NOP});
    for (int i = 0; i < 3; i++)
      step("t4_drn", I_NOP, 1'b0, 1'b1, 1'b0);
    step("t4_done", I_NOP, 1'b0, 1'b0, 1'b1);
    step("t4_idle", I_NOP, 1'b0, 1'b0, 1'b0);

    // start and halt_req together: start wins
    halt_req = 1'b1;
    go("t4b_st");
    drain("t4b");
    halt_req = 1'b0;

    // 5: reset while stalled, then identical rerun
    wr(1, I_SUB43);
    wr(2, I_HALT);
    go("t5");
    step("t5_add", I_ADD3, 1'b1, 1'b1, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_rst", {done, busy, instr_valid, instruction},
        {3'b000, I_NOP});
    chk("t5_pc", pc, 0);
    chk("t5_bcnt", bubble_count, 0);
    tick();
    reset = 1'b0;
    run_t2("t5r");

    // 6: no HALT, pc wrap and ignored write in RUN
    for (int i = 0; i < 16; i++)
      wr(i, 32'h4000_0000 | i);
    go("t6");
    for (int k = 1; k <= 22; k++) begin
      if (k == 3) begin
        prog_we   = 1'b1;
        prog_addr = 4'd5;
        prog_data = 32'hDEAD_BEEF;
      end
      step("t6_seq", 32'h4000_0000 | ((k - 1) % 16),
           1'b1, 1'b1, 1'b0);
      prog_we = 1'b0;
      if (k == 15) chk("t6_pc15", pc, 15);
      if (k == 16) chk("t6_wrap", pc, 0);
    end
    chk("t6_keep", instruction, 32'h4000_0005);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t6_h", {done, busy, instr_valid, instruction},
        {3'b010, I_NOP});
    for (int i = 0; i < 3; i++)
      step("t6_drn", I_NOP, 1'b0, 1'b1, 1'b0);
    step("t6_done", I_NOP, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
